// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button debounce front end: FSM state
// encodings and the default qualification window for the 50 MHz board clock.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_e;

    // 20 ms at 50 MHz
    localparam int DEF_STABLE_CYCLES = 1000000;
    localparam int DEF_CNT_W         = 20;

endpackage

// File: rtl/btn_debounce_sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; both stages reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule

// File: rtl/btn_debounce.sv
// Debounces a bouncy mechanical input: synchronises it, qualifies each level
// change over STABLE_CYCLES consecutive cycles, and emits registered edge pulses.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             w_s2;
    state_e           r_state;
    state_e           w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             r_level;
    logic             w_level_nx;
    logic             r_rise;
    logic             w_rise_nx;
    logic             r_fall;
    logic             w_fall_nx;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_raw),
        .q     (w_s2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE_LO;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_level <= w_level_nx;
            r_rise  <= w_rise_nx;
            r_fall  <= w_fall_nx;
        end
    end

    // Any sample disagreeing with the pending level drops back to the stable
    // state, so qualification always needs an unbroken run of STABLE_CYCLES.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_level_nx = r_level;
        w_rise_nx  = 1'b0;
        w_fall_nx  = 1'b0;
        case (r_state)
            IDLE_LO: begin
                if (w_s2) begin
                    w_state_nx = WAIT_HI;
                    w_cnt_nx   = '0;
                end
            end
            WAIT_HI: begin
                if (!w_s2) begin
                    w_state_nx = IDLE_LO;
                    w_cnt_nx   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nx = IDLE_HI;
                    w_cnt_nx   = '0;
                    w_level_nx = 1'b1;
                    w_rise_nx  = 1'b1;
                end else begin
                    w_cnt_nx   = r_cnt + 1'b1;
                end
            end
            IDLE_HI: begin
                if (!w_s2) begin
                    w_state_nx = WAIT_LO;
                    w_cnt_nx   = '0;
                end
            end
            WAIT_LO: begin
                if (w_s2) begin
                    w_state_nx = IDLE_HI;
                    w_cnt_nx   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nx = IDLE_LO;
                    w_cnt_nx   = '0;
                    w_level_nx = 1'b0;
                    w_fall_nx  = 1'b1;
                end else begin
                    w_cnt_nx   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = IDLE_LO;
                w_cnt_nx   = '0;
                w_level_nx = 1'b0;
            end
        endcase
    end

    assign btn_level = r_level;
    assign btn_rise  = r_rise;
    assign btn_fall  = r_fall;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with a 4-cycle qualification window.
module tb_btn_debounce;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_raw;
    logic btn_level;
    logic btn_rise;
    logic btn_fall;

    int n_chk  = 0;
    int n_pass = 0;

    int rise_edge;
    int fall_edge;
    int lvl_edge;
    int rises;
    int falls;

    btn_debounce #(
        .STABLE_CYCLES (4),
        .CNT_W         (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Drives pat[e] ahead of edge e+1 and records on which edge (1-based)
    // the first pulse / level change appears.
    task automatic watch(input int n, input logic [63:0] pat);
        logic lvl0;
        lvl0      = btn_level;
        rise_edge = 0;
        fall_edge = 0;
        lvl_edge  = 0;
        rises     = 0;
        falls     = 0;
        for (int e = 0; e < n; e++) begin
            btn_raw = (e < 64) ? pat[e] : pat[63];
            @(posedge clk);
            #1;
            if (btn_rise) begin
                rises++;
                if (rise_edge == 0) rise_edge = e + 1;
            end
            if (btn_fall) begin
                falls++;
                if (fall_edge == 0) fall_edge = e + 1;
            end
            if (btn_level != lvl0 && lvl_edge == 0) lvl_edge = e + 1;
        end
    endtask

    initial begin
        logic [63:0] gpat;
        logic        any_out;

        // Reset held with a toggling input
        rst_n   = 1'b0;
        btn_raw = 1'b0;
        any_out = 1'b0;
        @(posedge clk);
        #1;
        repeat (6) begin
            btn_raw = ~btn_raw;
            @(posedge clk);
            #1;
            any_out = any_out | btn_level | btn_rise | btn_fall;
        end
        chk("rst_outputs", int'(any_out), 0);
        chk("rst_level", int'(btn_level), 0);

        btn_raw = 1'b0;
        rst_n   = 1'b1;
        watch(20, 64'h0);
        chk("idle_rises", rises, 0);
        chk("idle_falls", falls, 0);
        chk("idle_level", int'(btn_level), 0);

        // Clean press
        watch(12, '1);
        chk("press_rise_edge", rise_edge, 7);
        chk("press_rises", rises, 1);
        chk("press_falls", falls, 0);
        chk("press_lvl_edge", lvl_edge, 7);
        chk("press_level", int'(btn_level), 1);
        chk("press_rise_idle", int'(btn_rise), 0);

        // Clean release
        watch(12, 64'h0);
        chk("rel_fall_edge", fall_edge, 7);
        chk("rel_falls", falls, 1);
        chk("rel_rises", rises, 0);
        chk("rel_lvl_edge", lvl_edge, 7);
        chk("rel_level", int'(btn_level), 0);

        // Bounce: high 2, low 1, then steady high from sample 4
        watch(16, 64'hFFFF_FFFF_FFFF_FFFB);
        chk("bounce_rise_edge", rise_edge, 10);
        chk("bounce_rises", rises, 1);
        chk("bounce_falls", falls, 0);
        chk("bounce_lvl_edge", lvl_edge, 10);
        chk("bounce_level", int'(btn_level), 1);

        // One-cycle low glitches every 3 cycles while held high
        for (int i = 0; i < 64; i++)
            gpat[i] = (i < 50 && (i % 3) == 0) ? 1'b0 : 1'b1;
        watch(58, gpat);
        chk("glitch_rises", rises, 0);
        chk("glitch_falls", falls, 0);
        chk("glitch_lvl_edge", lvl_edge, 0);
        chk("glitch_level", int'(btn_level), 1);

        // Asynchronous reset clears a high level without waiting for a clock
        rst_n = 1'b0;
        #1;
        chk("async_rst_level", int'(btn_level), 0);
        @(posedge clk);
        #1;
        btn_raw = 1'b0;
        rst_n   = 1'b1;
        watch(10, 64'h0);
        chk("post_rst_rises", rises, 0);
        chk("post_rst_level", int'(btn_level), 0);

        // Reset in the middle of WAIT_HI qualification (cnt == 2)
        watch(5, '1);
        chk("midq_rises", rises, 0);
        chk("midq_level", int'(btn_level), 0);
        rst_n = 1'b0;
        #1;
        chk("midq_rst_level", int'(btn_level), 0);
        chk("midq_rst_rise", int'(btn_rise), 0);
        rises = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (btn_rise) rises++;
        end
        chk("midq_held_rises", rises, 0);
        rst_n = 1'b1;
        watch(12, '1);
        chk("rerise_edge", rise_edge, 7);
        chk("rerise_rises", rises, 1);
        chk("rerise_level", int'(btn_level), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
